sdram_mem_arbiter: RTL and testbench
====================================

Name: sdram_mem_arbiter

Overview:
- Sits directly upstream of the SDRAM word-access adapter and drives its request side (rd_req_buf, wr_req_buf, mem_addr, indata, mem_size).
- Consumes the adapter's outputs rd_valid, wr_valid, outdata and init.
- Arbitrates between the RISC-V instruction-fetch port and the load/store data port. Issues one transaction at a time and holds it stable until the adapter completes it.
- Returns the result to the requesting port with a one-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 1024: busy cycles allowed before a transaction is abandoned.
- TO_W, 11: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held high until i_done
- i_addr  in  32  fetch byte address; stable while i_req is high
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held high until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_size  in  3  000 sb/lb, 001 lh, 010 word, 100 lbu, 101 lhu
- d_done  out  1  one-cycle pulse: data transaction complete
- d_rdata  out  32  load result
- err  out  1  sticky; set on timeout, cleared only by reset
- sd_init  in  1  adapter initialisation complete
- sd_rd_req  out  1  to adapter rd_req_buf
- sd_wr_req  out  1  to adapter wr_req_buf
- sd_addr  out  32  to adapter mem_addr
- sd_wdata  out  32  to adapter indata
- sd_size  out  3  to adapter mem_size
- sd_rd_valid  in  1  adapter read-complete pulse
- sd_wr_valid  in  1  adapter write-complete pulse
- sd_rdata  in  32  adapter outdata

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0. State = WAIT_INIT, last_grant = INSTR, timeout counter = 0, err = 0.
- States and transitions:
  - WAIT_INIT: no requests issued. Moves to IDLE on the first clock with sd_init = 1.
  - IDLE, neither request pending: stay in IDLE.
  - IDLE, only one request pending: grant it.
  - IDLE, both requests pending: round-robin; grant the port not in last_grant.
  - Grant to fetch: state = RD_I; sd_addr = i_addr, sd_size = 010.
  - Grant to data load: state = RD_D.
  - Grant to data store: state = WR_D.
  - For any data grant: sd_addr = d_addr, sd_size = d_size, sd_wdata = d_wdata.
  - On every grant: address, size and write data are registered. last_grant updates on grant.
- Request outputs:
  - sd_rd_req = 1 in RD_I and RD_D; sd_wr_req = 1 in WR_D.
  - Both are registered and asserted the cycle after the grant decision.
  - sd_addr, sd_size and sd_wdata never change while sd_rd_req or sd_wr_req is high.
- Completion:
  - RD_I with sd_rd_valid: i_rdata = sd_rdata, i_done pulses the next cycle, state = GAP.
  - RD_D with sd_rd_valid: d_rdata = sd_rdata, d_done pulses, state = GAP.
  - WR_D with sd_wr_valid: d_done pulses, d_rdata unchanged, state = GAP.
  - A valid pulse from the wrong kind (sd_wr_valid in a read state, sd_rd_valid in WR_D) is ignored.
- GAP:
  - Exactly one cycle with sd_rd_req = sd_wr_req = 0, so the adapter returns to idle. Then IDLE.
  - A requester that is still high in IDLE (not yet dropped after its done) is treated as a new request. Requesters must drop req in the cycle they see done.
- Latency: minimum request-to-done = adapter latency + 2 cycles (grant register + done register). Back-to-back throughput is one transaction per adapter latency + 3 cycles.
- Timeout:
  - Counter clears on grant and increments each cycle in RD_I, RD_D or WR_D.
  - At TIMEOUT_CYCLES-1 without a valid pulse: drop the request, set err.
  - The owning port gets a done pulse with rdata = 32'hDEADBEEF (data rdata unchanged for a store). Then GAP.
- Boundary cases:
  - sd_init falling while busy: ignored; the transaction continues.
  - sd_init low in IDLE: return to WAIT_INIT.
  - Requests arriving during WAIT_INIT: wait; they are served after init.
  - Reset mid-transaction: request lines drop immediately (asynchronous); no done pulse.
  - Undefined d_size codes (011, 11x): forwarded unchanged; the adapter defines the result.

Test Plan:
- Hold sd_init = 0 for 20 cycles with i_req = 1 -> no sd_rd_req. Raise sd_init -> sd_rd_req = 1 two cycles later, sd_addr = i_addr, sd_size = 010.
- Fetch i_addr = 0x100; adapter model returns 0x00000013 after 8 cycles -> i_done pulses 1 cycle with i_rdata = 0x00000013, followed by a 1-cycle gap with both requests low.
- i_req and d_req (load 0x200, size 100) raised in the same cycle after reset -> data is served first (last_grant = INSTR), then the fetch. Repeat with both held -> grants alternate I/D/I/D.
- Store d_we = 1, d_addr = 0x301, d_wdata = 0xAABBCCDD, d_size = 000 -> sd_wr_req is high with sd_wdata and sd_size stable until sd_wr_valid; d_done pulses; sd_rd_valid injected during WR_D is ignored.
- Adapter model never responds to a load -> after TIMEOUT_CYCLES cycles the request drops, err = 1 and stays 1, d_done pulses with d_rdata = 0xDEADBEEF. The next fetch still completes normally.
- Assert reset while sd_rd_req is high -> sd_rd_req = 0 without waiting for a clock, no done pulse; after release the block sits in WAIT_INIT until sd_init = 1.

Source files
------------

// File: rtl/sdram_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of the SDRAM word-access adapter.
// One transaction in flight, round-robin between ports, bounded by a busy timeout.
module sdram_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_size,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  input  logic        sd_init,
  output logic        sd_rd_req,
  output logic        sd_wr_req,
  output logic [31:0] sd_addr,
  output logic [31:0] sd_wdata,
  output logic [2:0]  sd_size,
  input  logic        sd_rd_valid,
  input  logic        sd_wr_valid,
  input  logic [31:0] sd_rdata
);

  localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {WAIT_INIT, IDLE, RD_I, RD_D, WR_D, GAP} state_t;

  state_t          state, state_nx;
  logic            last_d;
  logic [TO_W-1:0] to_cnt;
  logic            grant_i, grant_d, fin, tmo, busy, to_hit;

  assign busy   = (state == RD_I) || (state == RD_D) || (state == WR_D);
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    fin      = 1'b0;
    tmo      = 1'b0;
    case (state)
      WAIT_INIT: if (sd_init) state_nx = IDLE;
      IDLE: begin
        // both pending: the port that did not win last time goes first
        if (!sd_init) state_nx = WAIT_INIT;
        else if (i_req && (!d_req || last_d)) begin
          grant_i  = 1'b1;
          state_nx = RD_I;
        end else if (d_req) begin
          grant_d  = 1'b1;
          state_nx = d_we ? WR_D : RD_D;
        end
      end
      RD_I, RD_D: begin
        if (sd_rd_valid) fin = 1'b1;
        else if (to_hit) tmo = 1'b1;
      end
      WR_D: begin
        if (sd_wr_valid) fin = 1'b1;
        else if (to_hit) tmo = 1'b1;
      end
      GAP:     state_nx = IDLE;
      default: state_nx = WAIT_INIT;
    endcase
    if (fin || tmo) state_nx = GAP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_INIT;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sd_rd_req <= 1'b0;
      sd_wr_req <= 1'b0;
      sd_addr   <= '0;
      sd_wdata  <= '0;
      sd_size   <= '0;
      i_done    <= 1'b0;
      i_rdata   <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      last_d    <= 1'b0;
      to_cnt    <= '0;
    end else begin
      // request lines follow the next state so they drop in GAP and on timeout
      sd_rd_req <= (state_nx == RD_I) || (state_nx == RD_D);
      sd_wr_req <= (state_nx == WR_D);
      i_done    <= (state == RD_I) && (fin || tmo);
      d_done    <= ((state == RD_D) || (state == WR_D)) && (fin || tmo);

      if (state == RD_I) begin
        if (fin)      i_rdata <= sd_rdata;
        else if (tmo) i_rdata <= TMO_DATA;
      end
      if (state == RD_D) begin
        if (fin)      d_rdata <= sd_rdata;
        else if (tmo) d_rdata <= TMO_DATA;
      end
      if (tmo) err <= 1'b1;

      if (grant_i || grant_d) to_cnt <= '0;
      else if (busy)          to_cnt <= to_cnt + 1'b1;

      if (grant_i) begin
        last_d  <= 1'b0;
        sd_addr <= i_addr;
        sd_size <= 3'b010;
      end
      if (grant_d) begin
        last_d   <= 1'b1;
        sd_addr  <= d_addr;
        sd_size  <= d_size;
        sd_wdata <= d_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sdram_mem_arbiter.sv
// Bench for sdram_mem_arbiter: behavioural adapter + round-robin owner model,
// directed corner cases followed by randomized two-port traffic.
module tb_sdram_mem_arbiter;

  localparam int          TMO = 1024;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_done, d_req, d_we, d_done, err, sd_init;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [2:0]  d_size, sd_size;
  logic        sd_rd_req, sd_wr_req, sd_rd_valid, sd_wr_valid;
  logic [31:0] sd_addr, sd_wdata, sd_rdata;

  always #5 clk = ~clk;

  sdram_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .TO_W(11)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_done(d_done), .d_rdata(d_rdata), .err(err), .sd_init(sd_init),
    .sd_rd_req(sd_rd_req), .sd_wr_req(sd_wr_req), .sd_addr(sd_addr),
    .sd_wdata(sd_wdata), .sd_size(sd_size), .sd_rd_valid(sd_rd_valid),
    .sd_wr_valid(sd_wr_valid), .sd_rdata(sd_rdata)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_model(input logic [31:0] a, input logic [2:0] s);
    if (s == 3'b010 && mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ {29'd0, s} ^ 32'h1357_9BDF;
  endfunction

  // adapter model and transaction-level owner check
  int          wcnt = 0, ad_lat = 1, lat_force = 0;
  bit          ad_mute = 0, inj = 0, inj_force = 0;
  bit          own_d = 0, last_d_m = 0, exp_done = 0, is_wr = 0;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_size;
  bit          grant_log[$];

  initial begin : adapter
    sd_rd_valid = 0; sd_wr_valid = 0; sd_rdata = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (reset) #1;
      if (!reset) begin
        wcnt = 0; exp_done = 0; last_d_m = 0;
        sd_rd_valid = 0; sd_wr_valid = 0;
      end else begin
        sd_rd_valid = 0; sd_wr_valid = 0;
        if (exp_done) begin
          chk("done_port", 32'({i_done, d_done}), own_d ? 32'd1 : 32'd2);
          chk("gap_req", 32'({sd_rd_req, sd_wr_req}), 32'd0);
          exp_done = 0; wcnt = 0;
        end else if (!(sd_rd_req || sd_wr_req) && wcnt != 0) begin
          chk("req_len", 32'(wcnt), ad_mute ? 32'(TMO) : 32'(ad_lat));
          chk("tmo_done", 32'({i_done, d_done}), own_d ? 32'd1 : 32'd2);
          chk("err_set", 32'(err), 32'd1);
          wcnt = 0;
        end else begin
          if (i_done || d_done) chk("stray_done", 32'({i_done, d_done}), 32'd0);
          if (sd_rd_req || sd_wr_req) begin
            if (wcnt == 0) begin
              own_d = d_req && (!i_req || !last_d_m);
              is_wr = own_d && d_we;
              chk("grant_any", 32'(i_req | d_req), 32'd1);
              chk("req_kind", 32'({sd_rd_req, sd_wr_req}), is_wr ? 32'd1 : 32'd2);
              chk("req_addr", sd_addr, own_d ? d_addr : i_addr);
              chk("req_size", 32'(sd_size), 32'(own_d ? d_size : 3'b010));
              if (is_wr) chk("req_wdata", sd_wdata, d_wdata);
              s_addr = sd_addr; s_size = sd_size; s_wdata = sd_wdata;
              last_d_m = own_d;
              grant_log.push_back(own_d);
              ad_lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 10));
              inj = inj_force || ($urandom_range(0, 3) == 0);
            end
            wcnt++;
            if (!ad_mute && wcnt == ad_lat) begin
              chk("hold_addr", sd_addr, s_addr);
              chk("hold_size", 32'(sd_size), 32'(s_size));
              if (is_wr) begin
                chk("hold_wdata", sd_wdata, s_wdata);
                sd_wr_valid = 1;
              end else begin
                sd_rd_valid = 1;
                sd_rdata = rd_model(sd_addr, sd_size);
              end
              exp_done = 1;
            end else if (inj && wcnt == 1 && ad_lat >= 3) begin
              if (is_wr) sd_rd_valid = 1;
              else       sd_wr_valid = 1;
              sd_rdata = $urandom;
            end
          end
        end
      end
    end
  end

  // requester side: d_model tracks what d_rdata must hold
  logic [31:0] d_model = 0;
  bit          hit;

  task automatic fetch_txn(input logic [31:0] a);
    bit seen = 0;
    @(negedge clk);
    i_req = 1; i_addr = a;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      seen = i_done;
    end
    chk("i_done_seen", 32'(seen), 32'd1);
    if (seen) chk("i_rdata", i_rdata, ad_mute ? BAD : rd_model(a, 3'b010));
    i_req = 0;
  endtask

  task automatic data_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] sz);
    bit seen = 0;
    @(negedge clk);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_size = sz;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      seen = d_done;
    end
    chk("d_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      if (!we) d_model = ad_mute ? BAD : rd_model(a, sz);
      chk("d_rdata", d_rdata, d_model);
    end
    d_req = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    reset = 0; sd_init = 0; i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0;
    mem[32'h100] = 32'h0000_0013;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({sd_rd_req, sd_wr_req, i_done, d_done, err}), 32'd0);
    chk("rst_addr", sd_addr, 32'd0);
    chk("rst_wdata", sd_wdata, 32'd0);
    chk("rst_size", 32'(sd_size), 32'd0);
    chk("rst_irdata", i_rdata, 32'd0);
    chk("rst_drdata", d_rdata, 32'd0);
    reset = 1;

    // requests wait for init; first grant two edges after sd_init
    i_req = 1; i_addr = 32'h100; hit = 0;
    repeat (20) begin @(negedge clk); hit |= sd_rd_req; end
    chk("init_hold", 32'(hit), 32'd0);
    sd_init = 1; lat_force = 8;
    @(posedge clk); #1 chk("init_e1", 32'(sd_rd_req), 32'd0);
    @(posedge clk); #1 chk("init_e2", 32'(sd_rd_req), 32'd1);
    chk("init_addr", sd_addr, 32'h100);
    chk("init_size", 32'(sd_size), 32'd2);
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin @(negedge clk); hit = i_done; end
    chk("first_done", 32'(hit), 32'd1);
    chk("first_rdata", i_rdata, 32'h13);
    i_req = 0;

    // simultaneous requests: data first, then alternating
    lat_force = 0;
    grant_log.delete();
    for (int k = 0; k < 4; k++)
      fork
        fetch_txn(32'h400 + 32'(k * 4));
        data_txn(1'b0, 32'h200, 32'h0, 3'b100);
      join
    for (int k = 0; k < grant_log.size(); k++)
      chk("rr_order", 32'(grant_log[k]), 32'(k % 2 == 0));

    // store with a wrong-kind valid injected mid-transaction
    inj_force = 1; lat_force = 6;
    data_txn(1'b1, 32'h301, 32'hAABBCCDD, 3'b000);
    inj_force = 0;

    // sd_init drops while busy, then stays low across IDLE
    lat_force = 8;
    fork
      data_txn(1'b0, 32'h600, 32'h0, 3'b010);
      begin repeat (3) @(negedge clk); sd_init = 0; end
    join
    lat_force = 0;
    fork
      fetch_txn(32'h700);
      begin
        hit = 0;
        repeat (6) begin @(negedge clk); hit |= sd_rd_req; end
        chk("idle_init_low", 32'(hit), 32'd0);
        sd_init = 1;
      end
    join

    // timeout on a load, then normal service with err sticky
    ad_mute = 1;
    data_txn(1'b0, 32'h500, 32'h0, 3'b010);
    ad_mute = 0;
    chk("err_sticky", 32'(err), 32'd1);
    fetch_txn(32'h104);
    chk("err_after", 32'(err), 32'd1);

    // randomized two-port traffic
    fork
      for (int k = 0; k < 30; k++) begin
        fetch_txn($urandom & 32'hFFFF_FFFC);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int k = 0; k < 30; k++) begin
        data_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    join
    chk("err_end", 32'(err), 32'd1);

    // asynchronous reset mid-transaction
    lat_force = 20;
    @(negedge clk);
    i_req = 1; i_addr = 32'h900; hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin @(negedge clk); hit = sd_rd_req; end
    chk("pre_rst_req", 32'(hit), 32'd1);
    #2 reset = 0;
    #1 chk("async_drop", 32'({sd_rd_req, sd_wr_req}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    d_model = 0; sd_init = 0; hit = 0;
    repeat (3) begin @(negedge clk); hit |= i_done; end
    reset = 1;
    repeat (5) begin @(negedge clk); hit |= sd_rd_req | i_done; end
    chk("post_rst_wait", 32'(hit), 32'd0);
    sd_init = 1; lat_force = 0; hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin @(negedge clk); hit = i_done; end
    chk("post_rst_done", 32'(hit), 32'd1);
    chk("post_rst_rdata", i_rdata, rd_model(32'h900, 3'b010));
    i_req = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
